// File: rtl/uart_multi_frame_monitor_if.sv
// rtl/uart_multi_frame_monitor_if.sv - per-channel APB snoop bus and UART nets
interface uart_multi_frame_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16
);
    logic [NUM_CH-1:0]        psel;
    logic [NUM_CH-1:0]        penable;
    logic [NUM_CH-1:0]        pwrite;
    logic [NUM_CH*ADDR_W-1:0] paddr;
    logic [NUM_CH*32-1:0]     pwdata;
    logic [NUM_CH*4-1:0]      pstrb;
    logic [NUM_CH-1:0]        uart_net;

    modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, uart_net);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb, uart_net);
endinterface

// File: rtl/uart_multi_frame_monitor.sv
// rtl/uart_multi_frame_monitor.sv - N-channel UART frame decoder/checker snooping APB config
module uart_multi_frame_monitor #(
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] DIV_ADDR  = 'h04,
    parameter logic [ADDR_W-1:0] LCR_ADDR  = 'h08,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    uart_multi_frame_monitor_if.slave     bus,
    output logic [NUM_CH-1:0]             frame_valid,
    output logic [NUM_CH*8-1:0]           frame_data,
    output logic [NUM_CH-1:0]             parity_err,
    output logic [NUM_CH-1:0]             frame_err,
    output logic [NUM_CH-1:0]             start_err,
    output logic [NUM_CH-1:0]             break_det,
    output logic [NUM_CH-1:0]             cfg_err,
    output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t                 state;
        logic [15:0]            div_r, sh_div, cnt;
        logic [4:0]             lcr_r;
        logic [2:0]             sh_last, bit_idx;
        logic                   sh_stop2, sh_par_en, sh_even;
        logic                   sync1, sync2, prev;
        logic [7:0]             sr, data_q;
        logic                   par_acc, all_zero, perr, ferr_pend, brk_pend, stop_second;
        logic                   valid_q, perr_q, ferr_q, serr_q, brk_q;
        logic [ERR_CNT_W-1:0]   cnt_q;

        wire                    wr     = bus.psel[c] & bus.penable[c] & bus.pwrite[c];
        wire [ADDR_W-1:0]       addr   = bus.paddr[c*ADDR_W +: ADDR_W];
        wire [15:0]             wdata  = bus.pwdata[c*32 +: 16];
        wire [1:0]              strb   = bus.pstrb[c*4 +: 2];
        logic                   unused_bits;
        assign unused_bits = ^{bus.pwdata[c*32+16 +: 16], bus.pstrb[c*4+2 +: 2]};

        wire                    div_bad  = div_r < 16'd3;
        wire                    fall     = ~sync2 & prev;
        wire [16:0]             div_p1   = {1'b0, div_r} + 17'd1;
        wire [15:0]             half     = div_p1[16:1];
        wire [ERR_CNT_W-1:0]    cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + ERR_CNT_W'(1);
        // Break/framing are judged on the first stop sample; a second stop bit can only add a framing error
        wire                    fin_ferr = stop_second ? (ferr_pend | ~sync2) : ~sync2;
        wire                    fin_brk  = stop_second ? brk_pend : (all_zero & ~sync2);

        always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n) begin
                div_r <= '0;
                lcr_r <= '0;
            end else if (wr) begin
                if (addr == DIV_ADDR) begin
                    if (strb[0]) div_r[7:0]  <= wdata[7:0];
                    if (strb[1]) div_r[15:8] <= wdata[15:8];
                end
                if (addr == LCR_ADDR && strb[0]) lcr_r <= wdata[4:0];
            end
        end

        always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
                prev  <= 1'b1;
            end else begin
                sync1 <= bus.uart_net[c];
                sync2 <= sync1;
                prev  <= sync2;
            end
        end

        always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n) begin
                state <= IDLE;
                sh_div <= '0; cnt <= '0; sh_last <= '0; bit_idx <= '0;
                sh_stop2 <= 1'b0; sh_par_en <= 1'b0; sh_even <= 1'b0;
                sr <= '0; data_q <= '0; par_acc <= 1'b0; all_zero <= 1'b0;
                perr <= 1'b0; ferr_pend <= 1'b0; brk_pend <= 1'b0; stop_second <= 1'b0;
                valid_q <= 1'b0; perr_q <= 1'b0; ferr_q <= 1'b0; serr_q <= 1'b0; brk_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                serr_q  <= 1'b0;
                brk_q   <= 1'b0;
                case (state)
                    IDLE: if (!div_bad && fall) begin
                        sh_div    <= div_r;
                        sh_last   <= {1'b0, lcr_r[1:0]} + 3'd4;
                        sh_stop2  <= lcr_r[2];
                        sh_par_en <= lcr_r[3];
                        sh_even   <= lcr_r[4];
                        cnt       <= half - 16'd1;
                        state     <= START;
                    end
                    START: if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (sync2) begin
                        serr_q <= 1'b1;
                        cnt_q  <= cnt_sat;
                        state  <= IDLE;
                    end else begin
                        cnt <= sh_div; bit_idx <= '0; sr <= '0; par_acc <= 1'b0;
                        all_zero <= 1'b1; perr <= 1'b0; ferr_pend <= 1'b0;
                        brk_pend <= 1'b0; stop_second <= 1'b0;
                        state <= DATA;
                    end
                    DATA: if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        sr[bit_idx] <= sync2;
                        par_acc     <= par_acc ^ sync2;
                        all_zero    <= all_zero & ~sync2;
                        bit_idx     <= bit_idx + 3'd1;
                        cnt         <= sh_div;
                        if (bit_idx == sh_last) state <= sh_par_en ? PARITY : STOP;
                    end
                    PARITY: if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        perr     <= (par_acc ^ sync2) != ~sh_even;
                        all_zero <= all_zero & ~sync2;
                        cnt      <= sh_div;
                        state    <= STOP;
                    end
                    STOP: if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (sh_stop2 && !stop_second) begin
                        ferr_pend   <= ~sync2;
                        brk_pend    <= all_zero & ~sync2;
                        stop_second <= 1'b1;
                        cnt         <= sh_div;
                    end else begin
                        valid_q <= 1'b1;
                        data_q  <= sr;
                        perr_q  <= perr;
                        ferr_q  <= fin_ferr;
                        brk_q   <= fin_brk;
                        if (perr || fin_ferr) cnt_q <= cnt_sat;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign frame_valid[c]                    = valid_q;
        assign frame_data[c*8 +: 8]              = data_q;
        assign parity_err[c]                     = perr_q;
        assign frame_err[c]                      = ferr_q;
        assign start_err[c]                      = serr_q;
        assign break_det[c]                      = brk_q;
        assign cfg_err[c]                        = div_bad;
        assign err_cnt[c*ERR_CNT_W +: ERR_CNT_W] = cnt_q;
    end
endmodule

// File: tb/tb_uart_multi_frame_monitor.sv
// tb/tb_uart_multi_frame_monitor.sv - scoreboard bench for uart_multi_frame_monitor
module tb_uart_multi_frame_monitor;
    localparam int NUM_CH = 3, ADDR_W = 16, ERR_CNT_W = 2;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    always #5 pclk = ~pclk;

    uart_multi_frame_monitor_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus();

    logic [NUM_CH-1:0]           frame_valid, parity_err, frame_err, start_err, break_det, cfg_err;
    logic [NUM_CH*8-1:0]         frame_data;
    logic [NUM_CH*ERR_CNT_W-1:0] err_cnt;

    uart_multi_frame_monitor #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .pclk(pclk), .preset_n(preset_n), .bus(bus),
        .frame_valid(frame_valid), .frame_data(frame_data), .parity_err(parity_err),
        .frame_err(frame_err), .start_err(start_err), .break_det(break_det),
        .cfg_err(cfg_err), .err_cnt(err_cnt)
    );

    // {start_err, frame_valid, data[7:0], parity_err, frame_err, break_det}
    typedef logic [12:0] ev_t;
    ev_t q0[$], q1[$], q2[$];
    int checks = 0, failures = 0;

    always @(negedge pclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (frame_valid[c] | start_err[c] | parity_err[c] | frame_err[c] | break_det[c]) begin
                ev_t obs, exp_ev;
                logic have;
                have = 1'b0;
                exp_ev = '0;
                obs = {start_err[c], frame_valid[c], frame_valid[c] ? frame_data[c*8 +: 8] : 8'h00,
                       parity_err[c], frame_err[c], break_det[c]};
                case (c)
                    0: if (q0.size() != 0) begin have = 1'b1; exp_ev = q0.pop_front(); end
                    1: if (q1.size() != 0) begin have = 1'b1; exp_ev = q1.pop_front(); end
                    default: if (q2.size() != 0) begin have = 1'b1; exp_ev = q2.pop_front(); end
                endcase
                checks++;
                if (!have) begin
                    failures++;
                    $display("FAIL unexpected_event ch%0d actual=%h required=none", c, obs);
                end else if (obs !== exp_ev) begin
                    failures++;
                    $display("FAIL event ch%0d actual=%h required=%h", c, obs, exp_ev);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input int ch, input ev_t ev);
        case (ch)
            0: q0.push_back(ev);
            1: q1.push_back(ev);
            default: q2.push_back(ev);
        endcase
    endtask

    task automatic expect_frame(input int ch, input logic [7:0] d, input logic p, input logic f, input logic b);
        push(ch, {1'b0, 1'b1, d, p, f, b});
    endtask

    task automatic apb_write(input int ch, input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        tick();
        bus.psel[ch] = 1'b1;
        bus.pwrite[ch] = 1'b1;
        bus.paddr[ch*ADDR_W +: ADDR_W] = addr;
        bus.pwdata[ch*32 +: 32] = data;
        bus.pstrb[ch*4 +: 4] = strb;
        tick();
        bus.penable[ch] = 1'b1;
        tick();
        bus.psel[ch] = 1'b0;
        bus.penable[ch] = 1'b0;
        bus.pwrite[ch] = 1'b0;
    endtask

    task automatic send_frame(input int ch, input int period, input int nbits, input logic [7:0] d,
                              input logic par_en, input logic par_bit, input int nstop, input logic stop_val);
        bus.uart_net[ch] = 1'b0;
        repeat (period) tick();
        for (int i = 0; i < nbits; i++) begin
            bus.uart_net[ch] = d[i];
            repeat (period) tick();
        end
        if (par_en) begin
            bus.uart_net[ch] = par_bit;
            repeat (period) tick();
        end
        for (int i = 0; i < nstop; i++) begin
            bus.uart_net[ch] = stop_val;
            repeat (period) tick();
        end
        bus.uart_net[ch] = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int left;
        left = 3000;
        while ((q0.size() + q1.size() + q2.size()) != 0 && left > 0) begin
            tick();
            left--;
        end
        repeat (40) tick();
        check({name, "_drained"}, q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.psel = '0; bus.penable = '0; bus.pwrite = '0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        bus.uart_net = '1;
        repeat (3) tick();
        check("rst_frame_valid", frame_valid, 0);
        check("rst_err_pulses", {parity_err, frame_err, start_err, break_det}, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_cfg_err", cfg_err, 3'b111);
        preset_n = 1'b1;
        tick();

        // 8N1 at period 10, two frames back to back
        apb_write(0, 'h04, 32'h0000_0009, 4'b0011);
        apb_write(0, 'h08, 32'h0000_0003, 4'b0001);
        check("cfg_err_ch0_ok", cfg_err, 3'b110);
        expect_frame(0, 8'hA5, 0, 0, 0);
        expect_frame(0, 8'h01, 0, 0, 0);
        send_frame(0, 10, 8, 8'hA5, 0, 0, 1, 1'b1);
        send_frame(0, 10, 8, 8'h01, 0, 0, 1, 1'b1);
        wait_drain("8n1");
        check("err_cnt_ch0_clean", err_cnt[0 +: 2], 0);

        // 7E1: bad parity then good parity
        apb_write(0, 'h08, 32'h0000_001A, 4'b0001);
        expect_frame(0, 8'h41, 1, 0, 0);
        send_frame(0, 10, 7, 8'h41, 1, 1'b1, 1, 1'b1);
        expect_frame(0, 8'h43, 0, 0, 0);
        send_frame(0, 10, 7, 8'h43, 1, 1'b1, 1, 1'b1);
        wait_drain("7e1");
        check("err_cnt_ch0_parity", err_cnt[0 +: 2], 1);

        // 8N1 stop low, then full break
        apb_write(0, 'h08, 32'h0000_0003, 4'b0001);
        expect_frame(0, 8'h3C, 0, 1, 0);
        send_frame(0, 10, 8, 8'h3C, 0, 0, 1, 1'b0);
        repeat (20) tick();
        expect_frame(0, 8'h00, 0, 1, 1);
        send_frame(0, 10, 8, 8'h00, 0, 0, 1, 1'b0);
        wait_drain("ferr_break");
        check("err_cnt_ch0_ferr_brk", err_cnt[0 +: 2], 3);

        // ch1: 3-cycle glitches at DIV 15, counter saturates at 3
        apb_write(1, 'h04, 32'h0000_000F, 4'b0011);
        apb_write(1, 'h08, 32'h0000_0003, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            push(1, {1'b1, 1'b0, 8'h00, 3'b000});
            bus.uart_net[1] = 1'b0;
            repeat (3) tick();
            bus.uart_net[1] = 1'b1;
            repeat (40) tick();
        end
        wait_drain("glitch");
        check("err_cnt_ch1_sat", err_cnt[2 +: 2], 3);

        // DIV rewritten mid-frame: current frame keeps period 10
        expect_frame(0, 8'h5A, 0, 0, 0);
        fork
            send_frame(0, 10, 8, 8'h5A, 0, 0, 1, 1'b1);
            begin
                repeat (30) tick();
                apb_write(0, 'h04, 32'h0000_001F, 4'b0001);
            end
        join
        repeat (20) tick();
        expect_frame(0, 8'hC3, 0, 0, 0);
        send_frame(0, 32, 8, 8'hC3, 0, 0, 1, 1'b1);
        wait_drain("div_change");

        // ch2 5O2 at DIV 20 (upper byte not strobed) alongside ch0 8N1 at DIV 31
        apb_write(2, 'h04, 32'h0000_FF14, 4'b0001);
        apb_write(2, 'h08, 32'h0000_000C, 4'b0001);
        check("cfg_err_ch2_ok", cfg_err[2], 0);
        expect_frame(2, 8'h15, 0, 0, 0);
        expect_frame(0, 8'h99, 0, 0, 0);
        fork
            send_frame(2, 21, 5, 8'h15, 1, 1'b0, 2, 1'b1);
            send_frame(0, 32, 8, 8'h99, 0, 0, 1, 1'b1);
        join
        wait_drain("parallel");
        check("err_cnt_ch2_clean", err_cnt[4 +: 2], 0);

        // illegal divisor: line ignored
        apb_write(2, 'h04, 32'h0000_0002, 4'b0001);
        check("cfg_err_ch2_bad", cfg_err[2], 1);
        send_frame(2, 21, 5, 8'h0F, 1, 1'b1, 2, 1'b1);
        wait_drain("cfg_bad");

        // reset mid-frame on ch1
        fork
            send_frame(1, 16, 8, 8'h55, 0, 0, 1, 1'b1);
            begin
                repeat (50) tick();
                preset_n = 1'b0;
                #1;
                check("midrst_frame_valid", frame_valid, 0);
                check("midrst_err_cnt", err_cnt, 0);
                check("midrst_cfg_err", cfg_err, 3'b111);
                tick();
                preset_n = 1'b1;
            end
        join
        wait_drain("midrst");
        apb_write(1, 'h04, 32'h0000_000F, 4'b0011);
        apb_write(1, 'h08, 32'h0000_0003, 4'b0001);
        expect_frame(1, 8'h96, 0, 0, 0);
        send_frame(1, 16, 8, 8'h96, 0, 0, 1, 1'b1);
        wait_drain("recover");
        check("err_cnt_all_zero", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
